// File: rtl/sseg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// sseg_scan_ctrl
// Scan controller for a 4-digit multiplexed seven-segment display.
// Walks AN0..AN3 round-robin, inserts an all-dark gap between digits to stop
// ghosting, and drives hex-decoded segments plus the decimal point.
// New display values are staged on a load strobe and only become visible
// at a frame boundary, so an upstream counter can update at any time without
// tearing the frame that is currently on the display.
//
// Build option:
//   LEADING_ZERO_BLANK_EN - when defined, digits above the most-significant
//                           nonzero nibble are suppressed (digit 0 always
//                           stays lit). The mask is captured at commit time.
// ---------------------------------------------------------------------------
module sseg_scan_ctrl #(
    parameter int P_DIGIT_CYCLES = 4,   // cycles each digit is lit, >= 1
    parameter int P_BLANK_CYCLES = 1    // dark cycles between digits, >= 1
) (
    input  logic        i_w_clk,
    input  logic        i_w_reset,      // asynchronous, active-low
    input  logic        i_w_enable,
    input  logic        i_w_load,
    input  logic [15:0] i_w_value,
    input  logic [3:0]  i_w_dp,
    input  logic [3:0]  i_w_digit_en,
    output logic        o_r_AN0,
    output logic        o_r_AN1,
    output logic        o_r_AN2,
    output logic        o_r_AN3,
    output logic        o_r_CA,
    output logic        o_r_CB,
    output logic        o_r_CC,
    output logic        o_r_CD,
    output logic        o_r_CE,
    output logic        o_r_CF,
    output logic        o_r_CG,
    output logic        o_r_DP,
    output logic        o_r_frame
);

    // One slot counter serves both the lit and the blank phase, so it is
    // sized for whichever of the two is longer.
    localparam int CNT_MAX = (P_DIGIT_CYCLES > P_BLANK_CYCLES) ? P_DIGIT_CYCLES
                                                               : P_BLANK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(P_DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(P_BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ON    = 2'd1,
        S_BLANK = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [1:0]       idx_q;
    logic [1:0]       idx_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             frame_evt;        // this edge starts a new frame

    // Staging holds the most recent load until the next frame boundary.
    logic [15:0]      stg_value;
    logic [3:0]       stg_dp;
    logic [3:0]       stg_en;
    logic             pending_q;

    // Active set is what the scan actually shows for the current frame.
    logic [15:0]      act_value;
    logic [3:0]       act_dp;
    logic [3:0]       act_en;
    logic [3:0]       act_mask;

    // A load that coincides with a commit bypasses staging.
    logic [15:0]      cmt_value;
    logic [3:0]       cmt_dp;
    logic [3:0]       cmt_en;
    logic             do_commit;

    // Frame-start marker delayed one stage so it lines up with the pins.
    logic             frame_p0;

    // Combinational pin values derived from the current state register.
    logic [3:0]       an_d;
    logic [6:0]       seg_d;
    logic             dp_d;
    logic [3:0]       cur_nib;
    logic             lit_en;

    // Hex to segment pattern, bit 6 = CA ... bit 0 = CG, active-low.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0000100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    // Keep every digit up to and including the most-significant nonzero
    // nibble; digit 0 is always kept so a zero value still shows "0".
    function automatic logic [3:0] lead_zero_mask(input logic [15:0] value);
        logic [3:0] mask;
        if (value[15:12] != 4'h0) begin
            mask = 4'b1111;
        end else if (value[11:8] != 4'h0) begin
            mask = 4'b0111;
        end else if (value[7:4] != 4'h0) begin
            mask = 4'b0011;
        end else begin
            mask = 4'b0001;
        end
        return mask;
    endfunction
`endif

    // State, digit index and slot counter register.
    always_ff @(posedge i_w_clk or negedge i_w_reset) begin
        if (!i_w_reset) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: enable low always abandons the slot and goes dark.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        frame_evt = 1'b0;
        if (!i_w_enable) begin
            state_d = S_IDLE;
            idx_d   = 2'd0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d   = S_ON;
                    idx_d     = 2'd0;
                    cnt_d     = '0;
                    frame_evt = 1'b1;
                end
                S_ON: begin
                    if (cnt_q == ON_LAST) begin
                        state_d = S_BLANK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = S_ON;
                        cnt_d   = '0;
                        idx_d   = idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            frame_evt = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Commit source select: a same-cycle load wins over staging.
    always_comb begin
        cmt_value = i_w_load ? i_w_value    : stg_value;
        cmt_dp    = i_w_load ? i_w_dp       : stg_dp;
        cmt_en    = i_w_load ? i_w_digit_en : stg_en;
        // Leaving idle always commits; at a wrap only when something is new.
        do_commit = frame_evt && (i_w_load || pending_q || (state_q == S_IDLE));
    end

    // Staging registers and pending flag; last load in a frame wins.
    always_ff @(posedge i_w_clk or negedge i_w_reset) begin
        if (!i_w_reset) begin
            stg_value <= 16'h0000;
            stg_dp    <= 4'h0;
            stg_en    <= 4'hF;
            pending_q <= 1'b0;
        end else begin
            if (i_w_load) begin
                stg_value <= i_w_value;
                stg_dp    <= i_w_dp;
                stg_en    <= i_w_digit_en;
            end
            if (frame_evt) begin
                pending_q <= 1'b0;
            end else if (i_w_load) begin
                pending_q <= 1'b1;
            end
        end
    end

    // Active registers change only at a frame commit.
    always_ff @(posedge i_w_clk or negedge i_w_reset) begin
        if (!i_w_reset) begin
            act_value <= 16'h0000;
            act_dp    <= 4'h0;
            act_en    <= 4'hF;
            act_mask  <= 4'hF;
        end else if (do_commit) begin
            act_value <= cmt_value;
            act_dp    <= cmt_dp;
            act_en    <= cmt_en;
`ifdef LEADING_ZERO_BLANK_EN
            act_mask  <= lead_zero_mask(cmt_value);
`else
            act_mask  <= 4'hF;
`endif
        end
    end

    // Pin pattern for the digit currently selected by the state register.
    always_comb begin
        cur_nib = act_value[{idx_q, 2'b00} +: 4];
        lit_en  = act_en[idx_q] & act_mask[idx_q];
        an_d    = 4'hF;
        seg_d   = 7'h7F;
        dp_d    = 1'b1;
        if (state_q == S_ON) begin
            an_d[idx_q] = ~lit_en;
            if (lit_en) begin
                seg_d = hex_to_seg(cur_nib);
            end
            dp_d = ~(act_dp[idx_q] & lit_en);
        end
    end

    // ---- stage p0: frame marker captured alongside the state register ----
    always_ff @(posedge i_w_clk or negedge i_w_reset) begin
        if (!i_w_reset) begin
            frame_p0 <= 1'b0;
        end else begin
            frame_p0 <= frame_evt;
        end
    end

    // ---- stage p1: registered pins, one cycle behind the state register ----
    always_ff @(posedge i_w_clk or negedge i_w_reset) begin
        if (!i_w_reset) begin
            o_r_AN0   <= 1'b1;
            o_r_AN1   <= 1'b1;
            o_r_AN2   <= 1'b1;
            o_r_AN3   <= 1'b1;
            o_r_CA    <= 1'b1;
            o_r_CB    <= 1'b1;
            o_r_CC    <= 1'b1;
            o_r_CD    <= 1'b1;
            o_r_CE    <= 1'b1;
            o_r_CF    <= 1'b1;
            o_r_CG    <= 1'b1;
            o_r_DP    <= 1'b1;
            o_r_frame <= 1'b0;
        end else begin
            o_r_AN0   <= an_d[0];
            o_r_AN1   <= an_d[1];
            o_r_AN2   <= an_d[2];
            o_r_AN3   <= an_d[3];
            o_r_CA    <= seg_d[6];
            o_r_CB    <= seg_d[5];
            o_r_CC    <= seg_d[4];
            o_r_CD    <= seg_d[3];
            o_r_CE    <= seg_d[2];
            o_r_CF    <= seg_d[1];
            o_r_CG    <= seg_d[0];
            o_r_DP    <= dp_d;
            o_r_frame <= frame_p0;
        end
    end

endmodule

// File: doc/sseg_scan_ctrl.md
Name: sseg_scan_ctrl

Overview:
Scan controller for the 4-digit multiplexed seven-segment display on the lab board. Sequences anodes AN0..AN3 round-robin, inserts a blanking gap between digits against ghosting, and drives hex-decoded segments and the decimal point.
Commits a new display value only at a frame boundary, so a counter/FSM upstream (e.g. a button-driven counter) can update at any time without tearing.

Parameters:
P_DIGIT_CYCLES, 4, clock cycles each digit is lit (sim value; board builds override, e.g. 50000); must be >= 1
P_BLANK_CYCLES, 1, clock cycles all anodes off between digits; must be >= 1

Ports:
i_w_clk  input  1  system clock
i_w_reset  input  1  asynchronous, active-low reset
i_w_enable  input  1  1 = scanning, 0 = display dark
i_w_load  input  1  strobe: capture i_w_value/i_w_dp/i_w_digit_en into staging
i_w_value  input  16  four hex nibbles; [3:0] -> AN0 ... [15:12] -> AN3
i_w_dp  input  4  decimal point per digit, 1 = lit
i_w_digit_en  input  4  per-digit enable, 1 = digit may light
o_r_AN0..o_r_AN3  output  1 each  anode selects, active-low
o_r_CA..o_r_CG  output  1 each  segments a..g, active-low
o_r_DP  output  1  decimal point, active-low
o_r_frame  output  1  one-cycle pulse when a new frame starts (commit point)

Behaviour:
- Reset (i_w_reset=0, asynchronous): all AN, CA..CG, DP = 1; o_r_frame = 0; FSM = S_IDLE; digit index = 0; slot counter = 0; staging and active registers cleared (value 0, dp 0, digit_en 4'hF); pending = 0.
- FSM states: S_IDLE, S_ON, S_BLANK.
  - S_IDLE: outputs dark. When i_w_enable=1 -> S_ON, digit 0; commit staging -> active; pulse o_r_frame.
  - S_ON: counts P_DIGIT_CYCLES, then -> S_BLANK.
  - S_BLANK: counts P_BLANK_CYCLES. Then -> S_ON with index+1 (mod 4). On wrap 3->0: commit staging -> active if pending, clear pending, pulse o_r_frame.
  - i_w_enable=0 in any state -> S_IDLE next cycle. No drain; the current slot is abandoned.
- Frame length = 4*(P_DIGIT_CYCLES+P_BLANK_CYCLES) cycles (20 at defaults).
- Outputs are registered: pins reflect FSM state/index one cycle after the state register changes.
- In S_ON, digit k = index:
  - o_r_ANk = ~active_digit_en[k]; other anodes 1.
  - Segments = decode(active nibble k) when the digit is enabled, else all 1.
  - o_r_DP = ~(active_dp[k] & active_digit_en[k]).
- In S_BLANK/S_IDLE: all AN, segments, DP = 1.
- Decode, CA..CG order, active-low: 0=0000001 1=1001111 2=0010010 3=0000110 4=1001100 5=0100100 6=0100000 7=0001111 8=0000000 9=0000100 A=0001000 b=1100000 C=0110001 d=1000010 E=0110000 F=0111000.
- Staging and load:
  - i_w_load=1 captures all three inputs into staging and sets pending. Multiple loads within a frame: last wins.
  - Load in the same cycle as a commit: the loaded inputs bypass staging and are committed directly; pending ends 0.
  - Load while in S_IDLE is committed on leaving S_IDLE.
- Active values never change except at a commit. A mid-frame load is invisible until the next frame.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: digits above the most-significant nonzero nibble of the active value are treated as disabled (anode and DP off for the whole slot). Digit 0 is always shown, so value 0 displays a single "0". The mask is computed at commit time and ANDed with active_digit_en.
- Undefined: all enabled digits are shown, including leading zeros.

Test Plan:
1. Hold i_w_reset=0 with clock running and enable=1 -> all AN/CA..CG/DP = 1, o_r_frame = 0. Assert reset mid-slot later -> same values immediately, without waiting for a clock edge.
2. Release reset; load 16'h1234, en=4'hF, dp=0 -> from the next commit: AN0 low 4 cycles with CA..CG=1001100, 1 blank cycle all-high, AN1 with 0000110, and so on. o_r_frame pulses every 20 cycles.
3. During frame showing 1234, load 16'hABCD at frame cycle 7 -> digits 2,3 of that frame still show 2,1. Next frame AN0 shows d=1000010.
4. Load digit_en=4'b0101, dp=4'b0100 -> AN1/AN3 never low; DP low only during the AN2 slot.
5. Drop i_w_enable for 3 cycles mid-frame -> dark next cycle. On re-enable, scan restarts at AN0 with an o_r_frame pulse.
6. With LEADING_ZERO_BLANK_EN, load 16'h0070 -> AN3/AN2 stay high, AN1 shows 7 (0001111), AN0 shows 0 (0000001). Load 16'h0000 -> only AN0 lit, showing 0.
